// File: rtl/relu_maxpool.sv
// relu_maxpool: ReLU + 2x2/stride-2 streaming max pool over a Q4.6 map.
// Optional feature macro: RELU_EN (clamp negative samples to zero first).
module relu_maxpool #(
  parameter int DATA_WIDTH = 11, // BITS_Q4_6: sign + 4 int + 6 frac
  parameter int MAP_WIDTH  = 8,
  parameter int MAP_HEIGHT = 8
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         start_i,
  input  logic                         px_rdy_i,
  input  logic signed [DATA_WIDTH-1:0] px_i,
  output logic signed [DATA_WIDTH-1:0] out_px_o,
  output logic                         px_rdy_o,
  output logic                         frame_done_o
);

  localparam int CW = (MAP_WIDTH  > 1) ? $clog2(MAP_WIDTH)  : 1;
  localparam int RW = (MAP_HEIGHT > 1) ? $clog2(MAP_HEIGHT) : 1;
  localparam int BN = MAP_WIDTH / 2;
  localparam int BW = (BN > 1) ? $clog2(BN) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(MAP_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(MAP_HEIGHT - 1);

  typedef logic signed [DATA_WIDTH-1:0] px_t;

  function automatic px_t smax(input px_t a, input px_t b);
    return (a > b) ? a : b;
  endfunction

  logic [CW-1:0] col_q, col_d, col_c;
  logic [RW-1:0] row_q, row_d, row_c;
  px_t           hold_q, hold_d, hold_c;
  px_t           out_q, out_d;
  logic          rdy_q, rdy_d;
  logic          done_q, done_d;
  px_t           line_q [BN];
  px_t           line_wdata, line_rdata, v;
  logic          line_we;
  logic [BW-1:0] idx;

  always_comb begin
`ifdef RELU_EN
    v = px_i[DATA_WIDTH-1] ? '0 : px_i;
`else
    v = px_i;
`endif
  end

  always_comb begin
    // start_i restarts the frame; a coincident sample lands at (0,0)
    col_c      = start_i ? '0 : col_q;
    row_c      = start_i ? '0 : row_q;
    hold_c     = start_i ? '0 : hold_q;
    idx        = BW'(col_c >> 1);
    line_rdata = line_q[idx];
    line_wdata = smax(hold_c, v);
    line_we    = 1'b0;
    col_d      = col_c;
    row_d      = row_c;
    hold_d     = hold_c;
    out_d      = out_q;
    rdy_d      = 1'b0;
    done_d     = 1'b0;
    if (px_rdy_i) begin
      unique case ({row_c[0], col_c[0]})
        2'b00: hold_d = v;
        2'b01: line_we = 1'b1;
        2'b10: hold_d = smax(line_rdata, v);
        default: begin
          out_d  = smax(hold_c, v);
          rdy_d  = 1'b1;
          done_d = (row_c == ROW_LAST) && (col_c == COL_LAST);
        end
      endcase
      if (col_c == COL_LAST) begin
        col_d = '0;
        row_d = (row_c == ROW_LAST) ? '0 : row_c + 1'b1;
      end else begin
        col_d = col_c + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      col_q  <= '0;
      row_q  <= '0;
      hold_q <= '0;
      out_q  <= '0;
      rdy_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      hold_q <= hold_d;
      out_q  <= out_d;
      rdy_q  <= rdy_d;
      done_q <= done_d;
    end
  end

  // Written on every even row before the odd row reads it; no reset needed
  always_ff @(posedge clk_i) begin
    if (line_we) line_q[idx] <= line_wdata;
  end

  assign out_px_o     = out_q;
  assign px_rdy_o     = rdy_q;
  assign frame_done_o = done_q;

endmodule

// File: tb/tb_relu_maxpool.sv
// tb_relu_maxpool: randomized + directed bench for relu_maxpool on a 4x4 map.
// Reference model stores the whole frame and pools 2x2 blocks arithmetically.
module tb_relu_maxpool;

  localparam int DW = 11;
  localparam int W  = 4;
  localparam int H  = 4;
`ifdef RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 reset_i = 1'b1;
  logic                 start_i = 1'b0;
  logic                 px_rdy_i = 1'b0;
  logic signed [DW-1:0] px_i = '0;
  logic signed [DW-1:0] out_px_o;
  logic                 px_rdy_o;
  logic                 frame_done_o;

  relu_maxpool #(
    .DATA_WIDTH(DW),
    .MAP_WIDTH (W),
    .MAP_HEIGHT(H)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .start_i     (start_i),
    .px_rdy_i    (px_rdy_i),
    .px_i        (px_i),
    .out_px_o    (out_px_o),
    .px_rdy_o    (px_rdy_o),
    .frame_done_o(frame_done_o)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  int fr [H][W];
  int mr = 0, mc = 0;
  int exp_last = 0;
  bit exp_rdy = 1'b0, exp_done = 1'b0;
  bit chk_en = 1'b0;
  int got_q [$];
  bit gdone_q [$];

  int D1 [16] = '{64, 10, 0, 5, 3, 128, 7, 6, 1, 2, 3, 4, 9, 8, 7, 200};
  int D2 [16] = '{50, 10, 0, 5, 3, 20, 7, 6, 1, 2, 3, 4, 9, 8, 7, 200};
  int D3 [16] = '{-64, -10, 0, 5, -128, -5, 7, 6, 1, 2, 3, 4, 9, 8, 7, 200};

  task automatic chk(input string name, input int act, input int expv);
    n_total++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, expv, $time);
  endtask

  function automatic int act_fn(input int x);
    return (RELU && x < 0) ? 0 : x;
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic send(input bit s, input bit v, input int px);
    start_i  = s;
    px_rdy_i = v;
    px_i     = DW'(px);
    @(posedge clk);
    exp_rdy  = 1'b0;
    exp_done = 1'b0;
    if (s) begin
      mr = 0;
      mc = 0;
    end
    if (v) begin
      fr[mr][mc] = act_fn(px);
      if (mr % 2 == 1 && mc % 2 == 1) begin
        exp_last = max2(max2(fr[mr-1][mc-1], fr[mr-1][mc]),
                        max2(fr[mr][mc-1], fr[mr][mc]));
        exp_rdy  = 1'b1;
        exp_done = (mr == H - 1) && (mc == W - 1);
      end
      if (mc == W - 1) begin
        mc = 0;
        mr = (mr == H - 1) ? 0 : mr + 1;
      end else begin
        mc++;
      end
    end
    #1;
    start_i  = 1'b0;
    px_rdy_i = 1'b0;
  endtask

  task automatic flush(input int n);
    for (int i = 0; i < n; i++) send(1'b0, 1'b0, 0);
  endtask

  task automatic clear_got();
    got_q.delete();
    gdone_q.delete();
  endtask

  task automatic frame16(input int d [16], input int gap);
    for (int i = 0; i < 16; i++) begin
      send(1'b0, 1'b1, d[i]);
      for (int g = 0; g < gap; g++) send(1'b0, 1'b0, 0);
    end
  endtask

  task automatic check4(input string tag, input int a, input int b,
                        input int c, input int d);
    int ev [4];
    ev = '{a, b, c, d};
    chk({tag, "_count"}, got_q.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < got_q.size()) chk({tag, "_val"}, got_q[i], ev[i]);
    if (gdone_q.size() == 4) chk({tag, "_done_last"}, int'(gdone_q[3]), 1);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("px_rdy_o", int'(px_rdy_o), int'(exp_rdy));
      chk("frame_done_o", int'(frame_done_o), int'(exp_done));
      chk("out_px_o", int'(out_px_o), exp_last);
      if (px_rdy_o) begin
        got_q.push_back(int'(out_px_o));
        gdone_q.push_back(frame_done_o);
      end
    end
  end

  initial begin
    int nd;
    #3;
    chk("reset_out", int'(out_px_o), 0);
    chk("reset_rdy", int'(px_rdy_o), 0);
    chk("reset_done", int'(frame_done_o), 0);
    @(posedge clk);
    @(posedge clk);
    #2 reset_i = 1'b0;
    chk_en = 1'b1;

    clear_got();
    frame16(D1, 0);
    flush(2);
    check4("dense", 128, 7, 9, 200);

    clear_got();
    frame16(D1, 2);
    flush(2);
    check4("sparse", 128, 7, 9, 200);

    clear_got();
    frame16(D3, 0);
    flush(2);
    chk("neg_block", got_q.size() > 0 ? got_q[0] : 9999, RELU ? 0 : -5);

    clear_got();
    for (int i = 0; i < 5; i++) send(1'b0, 1'b1, D1[i]);
    send(1'b1, 1'b1, 50);
    for (int i = 1; i < 16; i++) send(1'b0, 1'b1, D2[i]);
    flush(2);
    check4("start_abort", 50, 7, 9, 200);

    clear_got();
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 16; i++)
        send(1'b0, 1'b1, $urandom_range(0, 2047) - 1024);
    flush(2);
    chk("b2b_count", got_q.size(), 8);
    nd = 0;
    foreach (gdone_q[i]) nd += int'(gdone_q[i]);
    chk("b2b_done_total", nd, 2);
    if (gdone_q.size() == 8) begin
      chk("b2b_done_4", int'(gdone_q[3]), 1);
      chk("b2b_done_8", int'(gdone_q[7]), 1);
    end

    for (int i = 0; i < 400; i++) begin
      bit s, v;
      s = ($urandom_range(0, 39) == 0);
      v = ($urandom_range(0, 2) != 0);
      send(s, v, $urandom_range(0, 2047) - 1024);
    end
    flush(2);

    send(1'b1, 1'b0, 0);
    for (int i = 0; i < 6; i++) send(1'b0, 1'b1, D1[i]);
    chk_en = 1'b0;
    reset_i = 1'b1;
    #1;
    chk("async_rst_out", int'(out_px_o), 0);
    chk("async_rst_rdy", int'(px_rdy_o), 0);
    chk("async_rst_done", int'(frame_done_o), 0);
    mr = 0;
    mc = 0;
    exp_last = 0;
    exp_rdy = 1'b0;
    exp_done = 1'b0;
    @(posedge clk);
    #2 reset_i = 1'b0;
    chk_en = 1'b1;
    clear_got();
    frame16(D1, 0);
    flush(2);
    check4("after_reset", 128, 7, 9, 200);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
